uart_ram_loader: RTL
====================

# uart_ram_loader

Synthesizable program loader for the 8-bit computer. It receives a framed program image over a UART RX line and writes it byte-by-byte into the machine's RAM write port. While loading, it holds the CPU halted, and it releases the CPU only after the frame's checksum verifies. It sits upstream of the machine's RAM, and it replaces simulation-only file loading on hardware.

## Interface
Parameters:
- CLKS_PER_BIT, 434, i_clk cycles per UART bit; minimum 4.
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- i_clk  in  1  system clock; one clock domain. All logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- i_rx  in  1  UART RX line, 8N1, LSB first, idle high, asynchronous to i_clk.
- o_ram_we  out  1  single-cycle RAM write strobe.
- o_ram_addr  out  ADDR_WIDTH  RAM write address.
- o_ram_data  out  8  RAM write data.
- o_cpu_halt  out  1  holds the machine clock halted while high.
- o_busy  out  1  high while a frame is in progress (states LEN, DATA, CSUM).
- o_done  out  1  level; high after a verified frame.
- o_error  out  1  level; high after a failed frame.

## Operation
- **RX front end**
  - i_rx passes through a 2-flop synchronizer.
  - A falling edge in idle starts a bit counter. At CLKS_PER_BIT/2 the start bit is re-checked; if it is high, the event is a glitch and the receiver returns to idle.
  - 8 data bits are sampled every CLKS_PER_BIT, LSB first, then the stop bit.
  - Stop bit = 1: an internal rx_valid pulse fires for one cycle with rx_byte.
  - Stop bit = 0: framing error. No rx_valid; the rx_ferr pulse fires instead.
- **Loader FSM states: SYNC, LEN, DATA, CSUM, DONE, ERR.**
  - SYNC: a byte equal to SYNC_BYTE goes to LEN. Other bytes are ignored.
  - LEN: stores L. L = 0 or L > DEPTH goes to ERR. Otherwise addr=0, sum=0, and the FSM goes to DATA.
  - DATA: each byte is written to RAM at addr. Then addr increments and sum += byte (8-bit, mod 256). After the L-th byte, the FSM goes to CSUM.
  - CSUM: byte == sum goes to DONE. A mismatch goes to ERR.
  - DONE / ERR: a byte equal to SYNC_BYTE goes to LEN, clears o_done/o_error and reasserts o_cpu_halt. Other bytes are ignored.
  - rx_ferr in LEN, DATA or CSUM goes to ERR. rx_ferr in SYNC, DONE or ERR is ignored.
- **Outputs**
  - o_cpu_halt is 0 only in DONE.
  - An error leaves the halt asserted, so a partially written RAM is never executed.
  - Bytes already written before an error remain in RAM; there is no rollback.
- **Address rules**
  - o_ram_addr holds the last written address between strobes.
  - When L = DEPTH, addr wraps to 0 after the final write and is not written again.

## Timing
- **Reset values:** o_ram_we=0, o_ram_addr=0, o_ram_data=0, o_cpu_halt=1, o_busy=0, o_done=0, o_error=0. FSM is in SYNC; RX is idle.
- **Reset mid-frame:** returns immediately to these values. The partial frame is discarded and the next valid frame is accepted normally.
- **rx_valid:** asserted the cycle after the stop-bit mid-sample.
- **RAM write:**
  - o_ram_we, o_ram_addr and o_ram_data are registered and asserted the cycle after rx_valid.
  - o_ram_we is high for exactly 1 cycle.
  - Addr/data are stable during the strobe.
- **End of frame:** o_done/o_error and o_cpu_halt update the cycle after the rx_valid (or rx_ferr) that causes the transition.
- **Byte spacing:** the minimum gap is one full frame (10*CLKS_PER_BIT cycles), so at most one byte is in flight. No backpressure; the RAM must accept a write every cycle.
- **Back-to-back frames:** a SYNC byte arriving in DONE re-halts the CPU 1 cycle after its rx_valid.

## Test plan
- **Normal load:** CLKS_PER_BIT=4; send A5 03 11 22 33 66 -> writes (0,11),(1,22),(2,33), one cycle each. Then o_done=1, o_cpu_halt=0, o_error=0.
- **Bad checksum:** send A5 02 01 02 04 -> writes (0,01),(1,02). Then o_error=1, o_cpu_halt stays 1. A following valid frame A5 01 7F 7F -> o_done=1, o_error=0.
- **Invalid length:** send A5 00, and separately A5 11 (DEPTH=16) -> ERR with no RAM writes. Full-depth frame A5 10 + 16 bytes + sum -> 16 writes at addrs 0..15, then o_done=1.
- **Noise rejection:** a 1-cycle low glitch on i_rx and a preamble 00 FF ahead of A5 01 5A 5A -> no spurious writes; single write (0,5A); o_done=1.
- **Framing error:** stop bit forced 0 on the second data byte of A5 03 ... -> o_error=1 after exactly 1 write. A stop-bit error while in SYNC -> ignored.
- **Async reset mid-DATA:** assert reset after the second write -> all outputs at reset values within the reset cycle. A subsequent full valid frame loads correctly.

Source files
------------

// File: rtl/uart_ram_loader.sv
// rtl/uart_ram_loader.sv - UART framed program loader that writes RAM and gates the CPU
//
// Purpose: receives SYNC_BYTE, length L, L data bytes and an 8-bit additive checksum
// over an 8N1 UART line. Each data byte is written to RAM. The CPU is released only
// after the checksum matches.
//
// Ports:
//   i_clk       system clock (rising edge)
//   reset       asynchronous active-high reset
//   i_rx        UART RX line (idle high, asynchronous to i_clk)
//   o_ram_we    single-cycle RAM write strobe
//   o_ram_addr  RAM write address (holds the last written address between strobes)
//   o_ram_data  RAM write data
//   o_cpu_halt  low only after a verified frame
//   o_busy      frame in progress (LEN, DATA, CSUM)
//   o_done      level, last frame verified
//   o_error     level, last frame failed
module uart_ram_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         ADDR_WIDTH   = 4,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                  i_clk,
    input  logic                  reset,
    input  logic                  i_rx,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [7:0]            o_ram_data,
    output logic                  o_cpu_halt,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    // ---------------- RX front end ----------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t       rx_state, rx_state_nxt;
    logic            rx_s1, rx_s2;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_byte;
    logic            rx_valid, rx_ferr;

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            R_IDLE:  if (!rx_s2) rx_state_nxt = R_START;
            // A start bit that is high again at mid-bit was only a glitch.
            R_START: if (clk_cnt == HALF_M1) rx_state_nxt = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (clk_cnt == FULL_M1 && bit_idx == 3'd7) rx_state_nxt = R_STOP;
            R_STOP:  if (clk_cnt == FULL_M1) rx_state_nxt = R_IDLE;
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= R_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1    <= i_rx;
            rx_s2    <= rx_s1;
            rx_state <= rx_state_nxt;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                end
                R_START: clk_cnt <= (clk_cnt == HALF_M1) ? '0 : clk_cnt + CW'(1);
                R_DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        rx_byte <= {rx_s2, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                R_STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt  <= '0;
                        rx_valid <= rx_s2;
                        rx_ferr  <= !rx_s2;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: clk_cnt <= '0;
            endcase
        end
    end

    // ---------------- Loader FSM ----------------
    typedef enum logic [2:0] {S_SYNC, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} ld_state_t;

    ld_state_t             state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            sum;
    logic [8:0]            rem;

    always_comb begin
        state_nxt  = state;
        o_cpu_halt = (state != S_DONE);
        o_busy     = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
        o_done     = (state == S_DONE);
        o_error    = (state == S_ERR);
        case (state)
            S_SYNC, S_DONE, S_ERR:
                if (rx_valid && rx_byte == SYNC_BYTE) state_nxt = S_LEN;
            S_LEN:
                if (rx_ferr) state_nxt = S_ERR;
                else if (rx_valid)
                    state_nxt = (rx_byte == 8'd0 || 32'(rx_byte) > DEPTH) ? S_ERR : S_DATA;
            S_DATA:
                if (rx_ferr) state_nxt = S_ERR;
                else if (rx_valid && rem == 9'd1) state_nxt = S_CSUM;
            S_CSUM:
                if (rx_ferr) state_nxt = S_ERR;
                else if (rx_valid) state_nxt = (rx_byte == sum) ? S_DONE : S_ERR;
            default: state_nxt = S_SYNC;
        endcase
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state      <= S_SYNC;
            addr       <= '0;
            sum        <= '0;
            rem        <= '0;
            o_ram_we   <= 1'b0;
            o_ram_addr <= '0;
            o_ram_data <= '0;
        end else begin
            state    <= state_nxt;
            o_ram_we <= 1'b0;
            if (rx_valid) begin
                case (state)
                    S_LEN: begin
                        addr <= '0;
                        sum  <= '0;
                        rem  <= {1'b0, rx_byte};
                    end
                    S_DATA: begin
                        // addr wraps to 0 after a full-depth frame; no further write follows.
                        o_ram_we   <= 1'b1;
                        o_ram_addr <= addr;
                        o_ram_data <= rx_byte;
                        addr       <= addr + ADDR_WIDTH'(1);
                        sum        <= sum + rx_byte;
                        rem        <= rem - 9'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
